latch_window_ctrl: RTL
======================

LATCH_WINDOW_CTRL -- requirements
Module: latch_window_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: width of the data path to the latch bank.
REQ-002 SHALL have parameter SETUP_CYC, default 1: cycles LD is stable before LG rises; 0 to 15.
REQ-003 SHALL have parameter OPEN_CYC, default 2: cycles LG is high; 1 to 15.
REQ-004 SHALL have parameter HOLD_CYC, default 1: cycles LD is held after LG falls; 0 to 15.
REQ-005 SHALL have port C, input, 1: clock; all state changes on the rising edge.
REQ-006 SHALL have port R, input, 1: reset, asynchronous, active-low.
REQ-007 SHALL have port DIN, input, DATA_WIDTH: write data from upstream.
REQ-008 SHALL have port DIN_VALID, input, 1: DIN is valid.
REQ-009 SHALL have port DIN_READY, output, 1: block accepts DIN this cycle.
REQ-010 SHALL have port CLR_REQ, input, 1: request a one-cycle clear pulse on the latch bank.
REQ-011 SHALL have port LD, output, DATA_WIDTH: drives D of the downstream LATCHR bank.
REQ-012 SHALL have port LG, output, 1: drives G, the level-sensitive gate, of the latch bank.
REQ-013 SHALL have port LR, output, 1: drives R, the active-high asynchronous reset, of the latch bank.
REQ-014 SHALL have port BUSY, output, 1: high in any state other than IDLE.

Function
REQ-015 SHALL implement the FSM states IDLE, SETUP, OPEN, HOLD and CLR, with one down-counter of 4 bits.
REQ-016 SHALL drive LD, LG and LR from registers only, so that no combinational glitch reaches the latch gate or reset.
REQ-017 SHALL assert DIN_READY only in IDLE when LR is low and CLR_REQ is low.
REQ-018 SHALL accept on a rising edge with DIN_VALID=1 and DIN_READY=1; on that edge:
- LD loads DIN.
- The FSM goes to SETUP with counter SETUP_CYC, or to OPEN with counter OPEN_CYC if SETUP_CYC=0.
REQ-019 SHALL hold LD constant in SETUP, OPEN and HOLD; LD changes only on an accept edge.
REQ-020 SHALL drive LG=1 only in OPEN.
REQ-021 SHALL make the state transitions when the counter reaches 1, decrementing otherwise:
- SETUP to OPEN.
- OPEN to HOLD, or to IDLE if HOLD_CYC=0.
- HOLD to IDLE.
REQ-022 SHALL stay in each timed state for exactly its parameter count of cycles; accept-to-next-accept spacing SHALL be SETUP_CYC+OPEN_CYC+HOLD_CYC cycles minimum.
REQ-023 SHALL handle CLR_REQ=1 sampled in IDLE as follows:
- Enter CLR, with LR=1 for exactly one cycle, then return to IDLE.
- LD is cleared to 0 on entry to CLR.
REQ-024 SHALL give CLR_REQ priority when CLR_REQ and DIN_VALID are both high in IDLE: no accept, DIN_READY=0.
REQ-025 SHALL ignore CLR_REQ outside IDLE; the requester holds it until BUSY=0.
REQ-026 SHALL ignore DIN when DIN_READY=0; DIN_VALID may drop without penalty.

Reset
REQ-027 SHALL on R=0 immediately force the following:
- FSM to IDLE, counter 0.
- LD=0, LG=0, LR=1, BUSY=0, DIN_READY=0.
REQ-028 SHALL release LR synchronously: LR stays 1 through the first two rising edges after R rises and goes 0 after the second.
REQ-029 SHALL abort any transaction on R=0 mid-operation; LG falls asynchronously with no completion.

Verification
REQ-030 SHALL pass this default-parameter accept test: DIN=0xA5, DIN_VALID=1 accepted at edge k.
- LD=0xA5 from edge k.
- LG=1 after edges k+1 and k+2.
- LG=0 from edge k+3.
- DIN_READY=1 after edge k+4.
REQ-031 SHALL pass this SETUP_CYC=0, HOLD_CYC=0, OPEN_CYC=1 back-to-back test: stream 0x01,0x02,0x03 with DIN_VALID held high.
- One accept per cycle pair.
- LG toggles 1,0,1,0,1.
- LD is never changed while LG=1.
REQ-032 SHALL pass this clear test: CLR_REQ=1 and DIN_VALID=1 (DIN=0x3C) in IDLE.
- LR=1 for exactly one cycle.
- LD=0x00.
- 0x3C is accepted on the following IDLE cycle.
REQ-033 SHALL pass this reset-mid-operation test: R=0 while LG=1.
- LG=0, LR=1, LD=0x00 without waiting for a clock edge.
- After R=1: LR=1 for 2 edges, then DIN_READY=1.
REQ-034 SHALL pass this maximum-parameter test: SETUP_CYC=15, OPEN_CYC=15, HOLD_CYC=15.
- LG high for exactly 15 cycles.
- Total BUSY time is 45 cycles.
- CLR_REQ asserted during BUSY has no effect until IDLE.

Source files
------------

// File: rtl/latch_window_ctrl.sv
`default_nettype none
// ============================================================================
// latch_window_ctrl : sequences setup / gate-open / hold windows and a
//                     one-cycle clear pulse for a downstream LATCHR bank.
// Revision 1.0
// ============================================================================
module latch_window_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int SETUP_CYC  = 1,   // 0..15
    parameter int OPEN_CYC   = 2,   // 1..15
    parameter int HOLD_CYC   = 1    // 0..15
) (
    input  logic                  C,
    input  logic                  R,
    input  logic [DATA_WIDTH-1:0] DIN,
    input  logic                  DIN_VALID,
    output logic                  DIN_READY,
    input  logic                  CLR_REQ,
    output logic [DATA_WIDTH-1:0] LD,
    output logic                  LG,
    output logic                  LR,
    output logic                  BUSY
);

    localparam logic [3:0] SETUP_LD  = 4'(SETUP_CYC);
    localparam logic [3:0] OPEN_LD   = 4'(OPEN_CYC);
    localparam logic [3:0] HOLD_LD   = 4'(HOLD_CYC);
    localparam bit         HAS_SETUP = (SETUP_CYC != 0);
    localparam bit         HAS_HOLD  = (HOLD_CYC != 0);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_OPEN  = 3'd2,
        S_HOLD  = 3'd3,
        S_CLR   = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] ld_q, ld_d;
    logic                  lg_q, lg_d;
    logic                  lr_q, lr_d;
    logic                  busy_q, busy_d;
    logic                  rel_q;
    logic                  w_idle_ok;
    logic                  w_accept;
    logic                  w_clear;

    // lr_q stays high through reset release, so it also gates new work
    assign w_idle_ok = (state_q == S_IDLE) && !lr_q;
    assign DIN_READY = w_idle_ok && !CLR_REQ;
    assign w_accept  = DIN_READY && DIN_VALID;
    assign w_clear   = w_idle_ok && CLR_REQ;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ld_d    = ld_q;
        case (state_q)
            S_IDLE: begin
                cnt_d = 4'd0;
                if (w_clear) begin
                    state_d = S_CLR;
                    ld_d    = '0;
                end else if (w_accept) begin
                    ld_d = DIN;
                    if (HAS_SETUP) begin
                        state_d = S_SETUP;
                        cnt_d   = SETUP_LD;
                    end else begin
                        state_d = S_OPEN;
                        cnt_d   = OPEN_LD;
                    end
                end
            end
            S_SETUP: begin
                if (cnt_q == 4'd1) begin
                    state_d = S_OPEN;
                    cnt_d   = OPEN_LD;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_OPEN: begin
                if (cnt_q == 4'd1) begin
                    if (HAS_HOLD) begin
                        state_d = S_HOLD;
                        cnt_d   = HOLD_LD;
                    end else begin
                        state_d = S_IDLE;
                        cnt_d   = 4'd0;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_HOLD: begin
                if (cnt_q == 4'd1) begin
                    state_d = S_IDLE;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_CLR: begin
                state_d = S_IDLE;
                cnt_d   = 4'd0;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 4'd0;
            end
        endcase

        // Outputs are decoded from the next state and registered, so the
        // latch gate and reset never see a combinational glitch.
        lg_d   = (state_d == S_OPEN);
        busy_d = (state_d != S_IDLE);
        lr_d   = !rel_q || (state_d == S_CLR);
    end

    always_ff @(posedge C or negedge R) begin
        if (!R) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            ld_q    <= '0;
            lg_q    <= 1'b0;
            lr_q    <= 1'b1;
            busy_q  <= 1'b0;
            rel_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ld_q    <= ld_d;
            lg_q    <= lg_d;
            lr_q    <= lr_d;
            busy_q  <= busy_d;
            rel_q   <= 1'b1;
        end
    end

    assign LD   = ld_q;
    assign LG   = lg_q;
    assign LR   = lr_q;
    assign BUSY = busy_q;

endmodule

`default_nettype wire
